mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit in the EX stage with architectural HI/LO registers.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit with HI/LO; MULT_CYCLES/DIV_CYCLES busy cycles, MTHI/MTLO single edge.
// Starts while busy are dropped (hazard unit stalls on md_stall); MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    opc_q, opc_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        long_op, is_div;
  logic        mul_sgn, div_sgn;
  logic [63:0] prod;
  logic [31:0] dvd, dvs_raw, dvs, uq, ur, quo, rem;

  always_comb begin
    long_op = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);

  // One shared multiplier: signed ops sign-extend to 64 bits, unsigned zero-extend.
  always_comb begin
    mul_sgn = (opc_q == OP_MULT);
`ifdef MDU_MADD_EN
    mul_sgn = mul_sgn || (opc_q == OP_MADD) || (opc_q == OP_MSUB);
`endif
    prod = {{32{mul_sgn & opa_q[31]}}, opa_q} * {{32{mul_sgn & opb_q[31]}}, opb_q};
  end

  // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  always_comb begin
    div_sgn = (opc_q == OP_DIV);
    dvd     = (div_sgn & opa_q[31]) ? (32'd0 - opa_q) : opa_q;
    dvs_raw = (div_sgn & opb_q[31]) ? (32'd0 - opb_q) : opb_q;
    dvs     = (dvs_raw == 32'd0) ? 32'd1 : dvs_raw;
    uq      = dvd / dvs;
    ur      = dvd % dvs;
    quo     = (div_sgn & (opa_q[31] ^ opb_q[31])) ? (32'd0 - uq) : uq;
    rem     = (div_sgn & opa_q[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (long_op) begin
            state_d = RUN;
            opc_d   = op;
            opa_d   = a;
            opb_d   = b;
            cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (opc_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_DIV, OP_DIVU: begin
              if (opb_q != 32'd0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opc_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = busy | (start & long_op);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit against an arithmetic HI/LO reference model.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ps, pu, acc;
    sx = $signed(x);
    sy = $signed(y);
    ps = sx * sy;
    pu = {32'd0, x} * {32'd0, y};
    acc = {hi_m, lo_m};
    case (o)
      4'd1: {hi_m, lo_m} = ps;
      4'd2: {hi_m, lo_m} = pu;
      4'd3: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      4'd4: if (y != 0) begin
        lo_m = x / y;
        hi_m = x % y;
      end
      4'd5: hi_m = x;
      4'd6: lo_m = x;
`ifdef MDU_MADD_EN
      4'd7:  {hi_m, lo_m} = acc + ps;
      4'd8:  {hi_m, lo_m} = acc + pu;
      4'd9:  {hi_m, lo_m} = acc - ps;
      4'd10: {hi_m, lo_m} = acc - pu;
`endif
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at a negedge after the op has fully completed.
  task automatic exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input bit poke, input logic [3:0] poke_op);
    int n;
    bit lng;
    lng = is_long(o);
    n = (o == 4'd3 || o == 4'd4) ? DC : MC;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    chk("md_stall_issue", {63'd0, md_stall}, {63'd0, lng});
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    if (lng) begin
      for (int i = 0; i < n; i++) begin
        chk("busy_run", {63'd0, busy}, 64'd1);
        chk("hilo_hold", {hi, lo}, {hi_m, lo_m});
        if (poke && i == 1) begin
          start = 1'b1; op = poke_op; a = 32'h12345678; b = 32'h3;
          #1;
          chk("md_stall_busy", {63'd0, md_stall}, 64'd1);
        end
        @(negedge clk);
        start = 1'b0; op = 4'd0;
      end
    end
    model_apply(o, x, y);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("hilo_result", {hi, lo}, {hi_m, lo_m});
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_stall", {63'd0, md_stall}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    exec(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 4'd0);
    chk("t1_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    exec(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0, 4'd0);
    chk("t2_multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    exec(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0, 4'd0);
    chk("t3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    exec(4'd4, 32'h00000007, 32'h00000000, 1'b0, 4'd0);
    chk("t3_divu_by0", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    exec(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 4'd0);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

    exec(4'd1, 32'h00000003, 32'hFFFFFFFE, 1'b1, 4'd5);
    chk("t4_mthi_ignored", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    exec(4'd5, 32'h12345678, 32'd0, 1'b0, 4'd0);
    chk("t4_mthi", {32'd0, hi}, 64'h12345678);

    // Reset pulse in the third DIV cycle aborts the operation outright.
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_hilo", {hi, lo}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exec(4'd3, 32'd100, 32'd7, 1'b0, 4'd0);
    chk("t5_div_after", {hi, lo}, {32'd2, 32'd14});

`ifdef MDU_MADD_EN
    exec(4'd6, 32'd1, 32'd0, 1'b0, 4'd0);
    exec(4'd5, 32'd0, 32'd0, 1'b0, 4'd0);
    exec(4'd7, 32'd3, 32'd4, 1'b0, 4'd0);
    chk("t6_madd", {hi, lo}, 64'h00000000_0000000D);
    exec(4'd10, 32'd1, 32'h0E, 1'b0, 4'd0);
    chk("t6_msubu", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
    exec(4'd7, 32'd3, 32'd4, 1'b0, 4'd0);
    chk("t6_op7_undef", {hi, lo}, {32'd2, 32'd14});
`endif

    for (int it = 0; it < 30; it++) begin
      ro  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (sel == 2) rb = 32'd1 + 32'($urandom_range(0, 9));
      exec(ro, ra, rb, ($urandom_range(0, 2) == 0), 4'($urandom_range(1, 10)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
